// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and widths used by the multilayer interconnect blocks.
package ahb_pkg;

    localparam int unsigned HADDR_W = 32;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    typedef enum logic {StIdle, StOwned} arb_state_e;

    // NONSEQ and SEQ carry a real transfer into the data phase.
    function automatic logic trans_active(input logic [1:0] trans);
        return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping around.
module rr_arbiter #(
    parameter int unsigned N    = 2,
    parameter int unsigned PtrW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req,
    input  logic [PtrW-1:0] ptr,
    output logic [N-1:0]    grant,
    output logic [PtrW-1:0] grant_idx,
    output logic            valid
);

    always_comb begin
        int unsigned     idx;
        logic [PtrW-1:0] sel;
        grant     = '0;
        grant_idx = '0;
        valid     = 1'b0;
        idx       = 0;
        sel       = '0;
        for (int unsigned off = 0; off < N; off++) begin
            idx = (32'(ptr) + off) % N;
            sel = PtrW'(idx);
            if (!valid && req[sel]) begin
                valid      = 1'b1;
                grant[sel] = 1'b1;
                grant_idx  = sel;
            end
        end
    end

endmodule

// File: rtl/ahb_slave_arbiter.sv
// Per-slave arbitration stage: round-robin grant of the slave port among master layers,
// address/control mux for the owner and data-phase routing of write data and responses.
module ahb_slave_arbiter
    import ahb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned DATA_W      = 32
) (
    input  logic                            i_hclk,
    input  logic                            i_hresetn,
    input  logic [NUM_MASTERS-1:0]          i_hsel,
    input  logic [HADDR_W*NUM_MASTERS-1:0]  i_haddr,
    input  logic [2*NUM_MASTERS-1:0]        i_htrans,
    input  logic [NUM_MASTERS-1:0]          i_hwrite,
    input  logic [3*NUM_MASTERS-1:0]        i_hsize,
    input  logic [3*NUM_MASTERS-1:0]        i_hburst,
    input  logic [NUM_MASTERS-1:0]          i_hmastlock,
    input  logic [DATA_W*NUM_MASTERS-1:0]   i_hwdata,
    input  logic                            i_hreadyout,
    input  logic                            i_hresp,
    output logic                            o_hsel,
    output logic [HADDR_W-1:0]              o_haddr,
    output logic [1:0]                      o_htrans,
    output logic                            o_hwrite,
    output logic [2:0]                      o_hsize,
    output logic [2:0]                      o_hburst,
    output logic                            o_hmastlock,
    output logic [DATA_W-1:0]               o_hwdata,
    output logic                            o_hready,
    output logic [NUM_MASTERS-1:0]          o_addr_ack,
    output logic [NUM_MASTERS-1:0]          o_hready_m,
    output logic [NUM_MASTERS-1:0]          o_hresp_m
);

    localparam int unsigned PtrW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    arb_state_e               state;
    logic [NUM_MASTERS-1:0]   addr_owner;
    logic [NUM_MASTERS-1:0]   data_owner;
    logic [PtrW-1:0]          rr_ptr;

    logic [NUM_MASTERS-1:0]   req;
    logic [NUM_MASTERS-1:0]   rr_grant;
    logic [PtrW-1:0]          rr_idx;
    logic                     rr_valid;

    logic                     owner_valid;
    logic                     own_sel;
    logic [HADDR_W-1:0]       own_addr;
    logic [1:0]               own_trans;
    logic                     own_write;
    logic [2:0]               own_size;
    logic [2:0]               own_burst;
    logic                     own_lock;
    logic [DATA_W-1:0]        data_wdata;
    logic                     hold;

    always_comb begin
        for (int m = 0; m < int'(NUM_MASTERS); m++) begin
            req[m] = i_hsel[m] && (i_htrans[2*m +: 2] == HTRANS_NONSEQ);
        end
    end

    rr_arbiter #(
        .N    (NUM_MASTERS),
        .PtrW (PtrW)
    ) u_rr_arbiter (
        .req       (req),
        .ptr       (rr_ptr),
        .grant     (rr_grant),
        .grant_idx (rr_idx),
        .valid     (rr_valid)
    );

    // Owners are one-hot, so a plain overwrite per set bit is a mux.
    always_comb begin
        own_sel    = 1'b0;
        own_addr   = '0;
        own_trans  = HTRANS_IDLE;
        own_write  = 1'b0;
        own_size   = '0;
        own_burst  = '0;
        own_lock   = 1'b0;
        data_wdata = '0;
        for (int m = 0; m < int'(NUM_MASTERS); m++) begin
            if (addr_owner[m]) begin
                own_sel   = i_hsel[m];
                own_addr  = i_haddr[HADDR_W*m +: HADDR_W];
                own_trans = i_htrans[2*m +: 2];
                own_write = i_hwrite[m];
                own_size  = i_hsize[3*m +: 3];
                own_burst = i_hburst[3*m +: 3];
                own_lock  = i_hmastlock[m];
            end
            if (data_owner[m]) begin
                data_wdata = i_hwdata[DATA_W*m +: DATA_W];
            end
        end
    end

    assign owner_valid = (state == StOwned);

    // Bursts in flight and locked sequences (even across deselected gaps) keep the port.
    assign hold = owner_valid &&
                  (own_lock || (own_sel && (own_trans == HTRANS_BUSY || own_trans == HTRANS_SEQ)));

    assign o_hsel      = owner_valid && own_sel;
    assign o_htrans    = o_hsel ? own_trans : HTRANS_IDLE;
    assign o_haddr     = own_addr;
    assign o_hwrite    = own_write;
    assign o_hsize     = own_size;
    assign o_hburst    = own_burst;
    assign o_hmastlock = own_lock;
    assign o_hwdata    = data_wdata;
    assign o_hready    = i_hreadyout;
    assign o_addr_ack  = addr_owner & {NUM_MASTERS{o_hsel && i_hreadyout}};
    assign o_hready_m  = ~data_owner | {NUM_MASTERS{i_hreadyout}};
    assign o_hresp_m   = data_owner & {NUM_MASTERS{i_hresp}};

    always_ff @(posedge i_hclk or negedge i_hresetn) begin
        if (!i_hresetn) begin
            state      <= StIdle;
            addr_owner <= '0;
            data_owner <= '0;
            rr_ptr     <= '0;
        end else if (i_hreadyout) begin
            data_owner <= (o_hsel && trans_active(o_htrans)) ? addr_owner : '0;
            if (!hold) begin
                if (rr_valid) begin
                    state      <= StOwned;
                    addr_owner <= rr_grant;
                    rr_ptr     <= (rr_idx == PtrW'(NUM_MASTERS - 1)) ? '0 : rr_idx + 1'b1;
                end else begin
                    state      <= StIdle;
                    addr_owner <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ahb_slave_arbiter.sv
// Directed plus randomized bench for ahb_slave_arbiter, checked against a per-cycle
// ownership model built from integer owner indices.
module tb_ahb_slave_arbiter;
    import ahb_pkg::*;

    localparam int NM = 2;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [NM-1:0]    hsel, hwrite, hmastlock;
    logic [32*NM-1:0] haddr;
    logic [2*NM-1:0]  htrans;
    logic [3*NM-1:0]  hsize, hburst;
    logic [DW*NM-1:0] hwdata;
    logic             hreadyout, hresp;

    logic             o_hsel, o_hwrite, o_hmastlock, o_hready;
    logic [31:0]      o_haddr;
    logic [1:0]       o_htrans;
    logic [2:0]       o_hsize, o_hburst;
    logic [DW-1:0]    o_hwdata;
    logic [NM-1:0]    o_addr_ack, o_hready_m, o_hresp_m;

    logic             m_sel   [NM];
    logic [31:0]      m_addr  [NM];
    logic [1:0]       m_trans [NM];
    logic             m_write [NM];
    logic [2:0]       m_size  [NM];
    logic [2:0]       m_burst [NM];
    logic             m_lock  [NM];
    logic [31:0]      m_wdata [NM];

    always_comb begin
        for (int m = 0; m < NM; m++) begin
            hsel[m]             = m_sel[m];
            haddr[32*m +: 32]   = m_addr[m];
            htrans[2*m +: 2]    = m_trans[m];
            hwrite[m]           = m_write[m];
            hsize[3*m +: 3]     = m_size[m];
            hburst[3*m +: 3]    = m_burst[m];
            hmastlock[m]        = m_lock[m];
            hwdata[DW*m +: DW]  = m_wdata[m];
        end
    end

    ahb_slave_arbiter #(
        .NUM_MASTERS (NM),
        .DATA_W      (DW)
    ) dut (
        .i_hclk      (clk),
        .i_hresetn   (rst_n),
        .i_hsel      (hsel),
        .i_haddr     (haddr),
        .i_htrans    (htrans),
        .i_hwrite    (hwrite),
        .i_hsize     (hsize),
        .i_hburst    (hburst),
        .i_hmastlock (hmastlock),
        .i_hwdata    (hwdata),
        .i_hreadyout (hreadyout),
        .i_hresp     (hresp),
        .o_hsel      (o_hsel),
        .o_haddr     (o_haddr),
        .o_htrans    (o_htrans),
        .o_hwrite    (o_hwrite),
        .o_hsize     (o_hsize),
        .o_hburst    (o_hburst),
        .o_hmastlock (o_hmastlock),
        .o_hwdata    (o_hwdata),
        .o_hready    (o_hready),
        .o_addr_ack  (o_addr_ack),
        .o_hready_m  (o_hready_m),
        .o_hresp_m   (o_hresp_m)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model state: owner indices, -1 meaning nobody.
    int own  = -1;
    int down = -1;
    int ptr  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic setm(input int m, input logic sel, input logic [1:0] tr, input logic [31:0] addr,
                        input logic lock, input logic [2:0] burst);
        m_sel[m]   = sel;
        m_trans[m] = tr;
        m_addr[m]  = addr;
        m_lock[m]  = lock;
        m_burst[m] = burst;
        m_write[m] = addr[2];
        m_size[m]  = 3'b010;
        m_wdata[m] = addr ^ 32'hA5A5_0000 ^ 32'(m);
    endtask

    task automatic idle_all();
        for (int m = 0; m < NM; m++) setm(m, 1'b0, HTRANS_IDLE, 32'h0, 1'b0, HBURST_SINGLE);
    endtask

    // Let the inputs settle, then compare every output against the model.
    task automatic eval();
        logic        s;
        logic [1:0]  tr;
        logic [31:0] a, wd;
        logic        w, lk;
        logic [2:0]  sz, bu;
        logic [NM-1:0] ack, rdy, rsp;
        #2;
        s  = (own >= 0) && m_sel[own];
        a  = '0; w = 1'b0; sz = '0; bu = '0; lk = 1'b0; tr = HTRANS_IDLE; wd = '0;
        if (own >= 0) begin
            a  = m_addr[own];
            w  = m_write[own];
            sz = m_size[own];
            bu = m_burst[own];
            lk = m_lock[own];
            if (s) tr = m_trans[own];
        end
        if (down >= 0) wd = m_wdata[down];
        for (int m = 0; m < NM; m++) begin
            ack[m] = (m == own) && s && hreadyout;
            rdy[m] = (m == down) ? hreadyout : 1'b1;
            rsp[m] = (m == down) ? hresp : 1'b0;
        end
        chk("hsel",      64'(o_hsel),      64'(s));
        chk("htrans",    64'(o_htrans),    64'(tr));
        chk("haddr",     64'(o_haddr),     64'(a));
        chk("hwrite",    64'(o_hwrite),    64'(w));
        chk("hsize",     64'(o_hsize),     64'(sz));
        chk("hburst",    64'(o_hburst),    64'(bu));
        chk("hmastlock", 64'(o_hmastlock), 64'(lk));
        chk("hwdata",    64'(o_hwdata),    64'(wd));
        chk("hready",    64'(o_hready),    64'(hreadyout));
        chk("addr_ack",  64'(o_addr_ack),  64'(ack));
        chk("hready_m",  64'(o_hready_m),  64'(rdy));
        chk("hresp_m",   64'(o_hresp_m),   64'(rsp));
    endtask

    // Advance the model across one clock edge using the inputs present before it.
    task automatic adv();
        int         n_own, n_down, n_ptr, mi;
        logic       s, keep;
        logic [1:0] tr;
        n_own = own; n_down = down; n_ptr = ptr;
        if (hreadyout) begin
            s      = (own >= 0) && m_sel[own];
            tr     = s ? m_trans[own] : HTRANS_IDLE;
            n_down = (s && (tr == HTRANS_NONSEQ || tr == HTRANS_SEQ)) ? own : -1;
            keep   = (own >= 0) && (m_lock[own] ||
                     (m_sel[own] && (m_trans[own] == HTRANS_BUSY || m_trans[own] == HTRANS_SEQ)));
            if (!keep) begin
                n_own = -1;
                for (int i = 0; i < NM; i++) begin
                    mi = (ptr + i) % NM;
                    if (n_own < 0 && m_sel[mi] && m_trans[mi] == HTRANS_NONSEQ) begin
                        n_own = mi;
                        n_ptr = (mi + 1) % NM;
                    end
                end
            end
        end
        @(posedge clk);
        own = n_own; down = n_down; ptr = n_ptr;
        #1;
    endtask

    task automatic cyc();
        eval();
        adv();
    endtask

    initial begin
        rst_n = 1'b0; hreadyout = 1'b1; hresp = 1'b0;
        idle_all();
        #12;
        chk("rst_hsel",     64'(o_hsel),     64'(0));
        chk("rst_htrans",   64'(o_htrans),   64'(0));
        chk("rst_hready_m", 64'(o_hready_m), 64'(2'b11));
        chk("rst_hready",   64'(o_hready),   64'(1));
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Contention straight out of reset: M0, M1, M0.
        setm(0, 1'b1, HTRANS_NONSEQ, 32'h100, 1'b0, HBURST_SINGLE);
        setm(1, 1'b1, HTRANS_NONSEQ, 32'h200, 1'b0, HBURST_SINGLE);
        cyc();
        eval(); chk("cont_r1", 64'(o_addr_ack), 64'(2'b01)); adv();
        setm(0, 1'b1, HTRANS_NONSEQ, 32'h104, 1'b0, HBURST_SINGLE);
        eval(); chk("cont_r2", 64'(o_addr_ack), 64'(2'b10)); adv();
        setm(1, 1'b1, HTRANS_NONSEQ, 32'h204, 1'b0, HBURST_SINGLE);
        eval(); chk("cont_r3", 64'(o_addr_ack), 64'(2'b01)); adv();
        idle_all(); cyc(); cyc();

        // Single transfer from M0, data phase with one wait state.
        setm(0, 1'b1, HTRANS_NONSEQ, 32'h10, 1'b0, HBURST_SINGLE);
        cyc();
        eval();
        chk("single_trans", 64'(o_htrans),   64'(HTRANS_NONSEQ));
        chk("single_ack",   64'(o_addr_ack), 64'(2'b01));
        chk("single_addr",  64'(o_haddr),    64'(32'h10));
        adv();
        idle_all(); hreadyout = 1'b0;
        eval(); chk("single_dphase_wait", 64'(o_hready_m), 64'(2'b10)); adv();
        hreadyout = 1'b1;
        eval(); chk("single_dphase_done", 64'(o_hready_m), 64'(2'b11)); adv();
        cyc(); cyc();

        // INCR4 by M1 while M0 requests from the first SEQ on.
        setm(1, 1'b1, HTRANS_NONSEQ, 32'h400, 1'b0, HBURST_INCR4);
        cyc();
        eval(); chk("burst_nonseq", 64'(o_addr_ack), 64'(2'b10)); adv();
        for (int b = 1; b < 4; b++) begin
            setm(1, 1'b1, HTRANS_SEQ, 32'h400 + 32'(4 * b), 1'b0, HBURST_INCR4);
            setm(0, 1'b1, HTRANS_NONSEQ, 32'h500, 1'b0, HBURST_SINGLE);
            eval(); chk("burst_seq_m0_held_off", 64'(o_addr_ack), 64'(2'b10)); adv();
        end
        setm(1, 1'b0, HTRANS_IDLE, 32'h0, 1'b0, HBURST_SINGLE);
        eval(); chk("burst_tail", 64'(o_addr_ack), 64'(2'b00)); adv();
        eval(); chk("burst_m0_ack", 64'(o_addr_ack), 64'(2'b01)); adv();
        idle_all(); cyc(); cyc();

        // Locked sequence from M0 with a deselected gap while M1 waits.
        setm(0, 1'b1, HTRANS_NONSEQ, 32'h600, 1'b1, HBURST_INCR);
        cyc();
        setm(1, 1'b1, HTRANS_NONSEQ, 32'h700, 1'b0, HBURST_SINGLE);
        eval(); chk("lock_first", 64'(o_addr_ack), 64'(2'b01)); adv();
        setm(0, 1'b0, HTRANS_IDLE, 32'h604, 1'b1, HBURST_INCR);
        eval();
        chk("lock_gap_trans", 64'(o_htrans),    64'(HTRANS_IDLE));
        chk("lock_gap_lock",  64'(o_hmastlock), 64'(1));
        chk("lock_gap_ack",   64'(o_addr_ack),  64'(2'b00));
        adv();
        setm(0, 1'b1, HTRANS_NONSEQ, 32'h604, 1'b1, HBURST_INCR);
        eval(); chk("lock_resume", 64'(o_addr_ack), 64'(2'b01)); adv();
        setm(0, 1'b0, HTRANS_IDLE, 32'h0, 1'b0, HBURST_SINGLE);
        cyc();
        eval(); chk("lock_m1_after", 64'(o_addr_ack), 64'(2'b10)); adv();
        idle_all(); cyc(); cyc();

        // Wait states in M0's data phase while M1 requests.
        setm(0, 1'b1, HTRANS_NONSEQ, 32'h800, 1'b0, HBURST_SINGLE);
        cyc();
        eval(); chk("wait_ack0", 64'(o_addr_ack), 64'(2'b01)); adv();
        setm(0, 1'b0, HTRANS_IDLE, 32'h0, 1'b0, HBURST_SINGLE);
        setm(1, 1'b1, HTRANS_NONSEQ, 32'h900, 1'b0, HBURST_SINGLE);
        hreadyout = 1'b0;
        for (int w = 0; w < 3; w++) begin
            eval();
            chk("wait_hready_m", 64'(o_hready_m), 64'(2'b10));
            chk("wait_no_ack",   64'(o_addr_ack), 64'(2'b00));
            adv();
        end
        hreadyout = 1'b1;
        eval(); chk("wait_release", 64'(o_hready_m), 64'(2'b11)); adv();
        setm(0, 1'b1, HTRANS_NONSEQ, 32'hA00, 1'b0, HBURST_SINGLE);
        eval(); chk("wait_m1_ack", 64'(o_addr_ack), 64'(2'b10)); adv();

        // ERROR in M1's data phase, then asynchronous reset mid-cycle.
        idle_all(); hresp = 1'b1; hreadyout = 1'b0;
        eval(); chk("err_resp", 64'(o_hresp_m), 64'(2'b10));
        rst_n = 1'b0;
        #1;
        chk("arst_hsel",     64'(o_hsel),     64'(0));
        chk("arst_htrans",   64'(o_htrans),   64'(0));
        chk("arst_haddr",    64'(o_haddr),    64'(0));
        chk("arst_hwdata",   64'(o_hwdata),   64'(0));
        chk("arst_ack",      64'(o_addr_ack), 64'(0));
        chk("arst_hready_m", 64'(o_hready_m), 64'(2'b11));
        chk("arst_hresp_m",  64'(o_hresp_m),  64'(0));
        own = -1; down = -1; ptr = 0;
        @(posedge clk); #1;
        rst_n = 1'b1; hresp = 1'b0; hreadyout = 1'b1;
        setm(0, 1'b1, HTRANS_NONSEQ, 32'hB00, 1'b0, HBURST_SINGLE);
        setm(1, 1'b1, HTRANS_NONSEQ, 32'hC00, 1'b0, HBURST_SINGLE);
        cyc();
        eval(); chk("post_rst_m0_first", 64'(o_addr_ack), 64'(2'b01)); adv();

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            for (int m = 0; m < NM; m++) begin
                m_sel[m]   = ($urandom_range(0, 3) != 0);
                m_trans[m] = 2'($urandom);
                m_addr[m]  = $urandom;
                m_write[m] = 1'($urandom);
                m_size[m]  = 3'($urandom);
                m_burst[m] = 3'($urandom);
                m_lock[m]  = ($urandom_range(0, 7) == 0);
                m_wdata[m] = $urandom;
            end
            hreadyout = ($urandom_range(0, 3) != 0);
            hresp     = 1'($urandom);
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
